// File: rtl/axi_rr_arbiter_2to1.sv
// Two-requester AXI4 round-robin arbiter onto one downstream slave.
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, one transaction each.
module axi_rr_arbiter_2to1 #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   s0_aw_addr,
    input  logic [7:0]          s0_aw_len,
    input  logic [2:0]          s0_aw_size,
    input  logic [1:0]          s0_aw_burst,
    input  logic [2:0]          s0_aw_prot,
    input  logic [ID_W-1:0]     s0_aw_id,
    input  logic                s0_aw_valid,
    output logic                s0_aw_ready,
    input  logic [DATA_W-1:0]   s0_w_data,
    input  logic [DATA_W/8-1:0] s0_w_strb,
    input  logic                s0_w_last,
    input  logic                s0_w_valid,
    output logic                s0_w_ready,
    output logic [1:0]          s0_b_resp,
    output logic [ID_W-1:0]     s0_b_id,
    output logic                s0_b_valid,
    input  logic                s0_b_ready,
    input  logic [ADDR_W-1:0]   s0_ar_addr,
    input  logic [7:0]          s0_ar_len,
    input  logic [2:0]          s0_ar_size,
    input  logic [1:0]          s0_ar_burst,
    input  logic [2:0]          s0_ar_prot,
    input  logic [ID_W-1:0]     s0_ar_id,
    input  logic                s0_ar_valid,
    output logic                s0_ar_ready,
    output logic [DATA_W-1:0]   s0_r_data,
    output logic [1:0]          s0_r_resp,
    output logic                s0_r_last,
    output logic [ID_W-1:0]     s0_r_id,
    output logic                s0_r_valid,
    input  logic                s0_r_ready,
    input  logic [ADDR_W-1:0]   s1_aw_addr,
    input  logic [7:0]          s1_aw_len,
    input  logic [2:0]          s1_aw_size,
    input  logic [1:0]          s1_aw_burst,
    input  logic [2:0]          s1_aw_prot,
    input  logic [ID_W-1:0]     s1_aw_id,
    input  logic                s1_aw_valid,
    output logic                s1_aw_ready,
    input  logic [DATA_W-1:0]   s1_w_data,
    input  logic [DATA_W/8-1:0] s1_w_strb,
    input  logic                s1_w_last,
    input  logic                s1_w_valid,
    output logic                s1_w_ready,
    output logic [1:0]          s1_b_resp,
    output logic [ID_W-1:0]     s1_b_id,
    output logic                s1_b_valid,
    input  logic                s1_b_ready,
    input  logic [ADDR_W-1:0]   s1_ar_addr,
    input  logic [7:0]          s1_ar_len,
    input  logic [2:0]          s1_ar_size,
    input  logic [1:0]          s1_ar_burst,
    input  logic [2:0]          s1_ar_prot,
    input  logic [ID_W-1:0]     s1_ar_id,
    input  logic                s1_ar_valid,
    output logic                s1_ar_ready,
    output logic [DATA_W-1:0]   s1_r_data,
    output logic [1:0]          s1_r_resp,
    output logic                s1_r_last,
    output logic [ID_W-1:0]     s1_r_id,
    output logic                s1_r_valid,
    input  logic                s1_r_ready,
    output logic [ADDR_W-1:0]   m_aw_addr,
    output logic [7:0]          m_aw_len,
    output logic [2:0]          m_aw_size,
    output logic [1:0]          m_aw_burst,
    output logic [2:0]          m_aw_prot,
    output logic [ID_W-1:0]     m_aw_id,
    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_strb,
    output logic                m_w_last,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    input  logic [1:0]          m_b_resp,
    input  logic [ID_W-1:0]     m_b_id,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    output logic [ADDR_W-1:0]   m_ar_addr,
    output logic [7:0]          m_ar_len,
    output logic [2:0]          m_ar_size,
    output logic [1:0]          m_ar_burst,
    output logic [2:0]          m_ar_prot,
    output logic [ID_W-1:0]     m_ar_id,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    input  logic [DATA_W-1:0]   m_r_data,
    input  logic [1:0]          m_r_resp,
    input  logic                m_r_last,
    input  logic [ID_W-1:0]     m_r_id,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    output logic [1:0]          grant_w_o,
    output logic [1:0]          grant_r_o
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e   w_state_q, w_state_d;
    r_state_e   r_state_q, r_state_d;
    logic [1:0] gnt_w_q, gnt_w_d, gnt_r_q, gnt_r_d;
    logic       wr_prio_q, wr_prio_d, rd_prio_q, rd_prio_d;
    logic       aw_sel, w_sel, ar_sel;
    logic       aw_vld, w_vld, w_lst, b_rdy, ar_vld, r_rdy;

    // One-hot winner; prio=1 favours s1 on a tie
    function automatic logic [1:0] pick(input logic v0, input logic v1, input logic prio);
        if (v0 && v1) return prio ? 2'b10 : 2'b01;
        return v1 ? 2'b10 : 2'b01;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            gnt_w_q   <= 2'b00;
            gnt_r_q   <= 2'b00;
            wr_prio_q <= 1'b0;
            rd_prio_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            gnt_w_q   <= gnt_w_d;
            gnt_r_q   <= gnt_r_d;
            wr_prio_q <= wr_prio_d;
            rd_prio_q <= rd_prio_d;
        end
    end

    assign grant_w_o = gnt_w_q;
    assign grant_r_o = gnt_r_q;

    // Payload muxes select s1 only while s1 owns the corresponding phase
    assign aw_sel = (w_state_q == W_ADDR) && gnt_w_q[1];
    assign w_sel  = (w_state_q == W_DATA) && gnt_w_q[1];
    assign ar_sel = (r_state_q == R_ADDR) && gnt_r_q[1];

    assign m_aw_addr  = aw_sel ? s1_aw_addr  : s0_aw_addr;
    assign m_aw_len   = aw_sel ? s1_aw_len   : s0_aw_len;
    assign m_aw_size  = aw_sel ? s1_aw_size  : s0_aw_size;
    assign m_aw_burst = aw_sel ? s1_aw_burst : s0_aw_burst;
    assign m_aw_prot  = aw_sel ? s1_aw_prot  : s0_aw_prot;
    assign m_aw_id    = aw_sel ? s1_aw_id    : s0_aw_id;
    assign m_w_data   = w_sel  ? s1_w_data   : s0_w_data;
    assign m_w_strb   = w_sel  ? s1_w_strb   : s0_w_strb;
    assign m_w_last   = w_sel  ? s1_w_last   : s0_w_last;
    assign m_ar_addr  = ar_sel ? s1_ar_addr  : s0_ar_addr;
    assign m_ar_len   = ar_sel ? s1_ar_len   : s0_ar_len;
    assign m_ar_size  = ar_sel ? s1_ar_size  : s0_ar_size;
    assign m_ar_burst = ar_sel ? s1_ar_burst : s0_ar_burst;
    assign m_ar_prot  = ar_sel ? s1_ar_prot  : s0_ar_prot;
    assign m_ar_id    = ar_sel ? s1_ar_id    : s0_ar_id;

    assign s0_b_resp = m_b_resp;
    assign s1_b_resp = m_b_resp;
    assign s0_b_id   = m_b_id;
    assign s1_b_id   = m_b_id;
    assign s0_r_data = m_r_data;
    assign s1_r_data = m_r_data;
    assign s0_r_resp = m_r_resp;
    assign s1_r_resp = m_r_resp;
    assign s0_r_last = m_r_last;
    assign s1_r_last = m_r_last;
    assign s0_r_id   = m_r_id;
    assign s1_r_id   = m_r_id;

    assign aw_vld = gnt_w_q[1] ? s1_aw_valid : s0_aw_valid;
    assign w_vld  = gnt_w_q[1] ? s1_w_valid  : s0_w_valid;
    assign w_lst  = gnt_w_q[1] ? s1_w_last   : s0_w_last;
    assign b_rdy  = gnt_w_q[1] ? s1_b_ready  : s0_b_ready;
    assign ar_vld = gnt_r_q[1] ? s1_ar_valid : s0_ar_valid;
    assign r_rdy  = gnt_r_q[1] ? s1_r_ready  : s0_r_ready;

    // Write path
    always_comb begin
        w_state_d   = w_state_q;
        gnt_w_d     = gnt_w_q;
        wr_prio_d   = wr_prio_q;
        m_aw_valid  = 1'b0;
        m_w_valid   = 1'b0;
        m_b_ready   = 1'b0;
        s0_aw_ready = 1'b0;
        s1_aw_ready = 1'b0;
        s0_w_ready  = 1'b0;
        s1_w_ready  = 1'b0;
        s0_b_valid  = 1'b0;
        s1_b_valid  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s0_aw_valid || s1_aw_valid) begin
                    gnt_w_d   = pick(s0_aw_valid, s1_aw_valid, wr_prio_q);
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                m_aw_valid  = aw_vld;
                s0_aw_ready = gnt_w_q[0] & m_aw_ready;
                s1_aw_ready = gnt_w_q[1] & m_aw_ready;
                if (aw_vld && m_aw_ready) w_state_d = W_DATA;
            end
            W_DATA: begin
                m_w_valid  = w_vld;
                s0_w_ready = gnt_w_q[0] & m_w_ready;
                s1_w_ready = gnt_w_q[1] & m_w_ready;
                if (w_vld && m_w_ready && w_lst) w_state_d = W_RESP;
            end
            W_RESP: begin
                m_b_ready  = b_rdy;
                s0_b_valid = gnt_w_q[0] & m_b_valid;
                s1_b_valid = gnt_w_q[1] & m_b_valid;
                if (m_b_valid && b_rdy) begin
                    w_state_d = W_IDLE;
                    gnt_w_d   = 2'b00;
                    wr_prio_d = ~gnt_w_q[1];
                end
            end
        endcase
    end

    // Read path
    always_comb begin
        r_state_d   = r_state_q;
        gnt_r_d     = gnt_r_q;
        rd_prio_d   = rd_prio_q;
        m_ar_valid  = 1'b0;
        m_r_ready   = 1'b0;
        s0_ar_ready = 1'b0;
        s1_ar_ready = 1'b0;
        s0_r_valid  = 1'b0;
        s1_r_valid  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (s0_ar_valid || s1_ar_valid) begin
                    gnt_r_d   = pick(s0_ar_valid, s1_ar_valid, rd_prio_q);
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_ar_valid  = ar_vld;
                s0_ar_ready = gnt_r_q[0] & m_ar_ready;
                s1_ar_ready = gnt_r_q[1] & m_ar_ready;
                if (ar_vld && m_ar_ready) r_state_d = R_DATA;
            end
            R_DATA: begin
                m_r_ready  = r_rdy;
                s0_r_valid = gnt_r_q[0] & m_r_valid;
                s1_r_valid = gnt_r_q[1] & m_r_valid;
                if (m_r_valid && r_rdy && m_r_last) begin
                    r_state_d = R_IDLE;
                    gnt_r_d   = 2'b00;
                    rd_prio_d = ~gnt_r_q[1];
                end
            end
            default: begin
                r_state_d = R_IDLE;
                gnt_r_d   = 2'b00;
            end
        endcase
    end

endmodule
